// File: rtl/digital_mem_sram_pkg.sv
// Shared definitions for the digital_mem SRAM responder: FSM encoding,
// access-size codes, wait-counter width and lane-mask helpers.
package digital_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    localparam logic [3:0] MEM_SZ_B = 4'd1;
    localparam logic [3:0] MEM_SZ_H = 4'd2;
    localparam logic [3:0] MEM_SZ_W = 4'd4;

    localparam int WAIT_CNT_W = 4;

    // Lanes touched by an access of the given size, before shifting to the address offset.
    function automatic logic [3:0] size_lanes(input logic [3:0] size);
        case (size)
            MEM_SZ_B: size_lanes = 4'b0001;
            MEM_SZ_H: size_lanes = 4'b0011;
            MEM_SZ_W: size_lanes = 4'b1111;
            default:  size_lanes = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
        lane_bits = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

endpackage

// File: rtl/digital_mem_sram_if.sv
// Bus bundle between the SoC digital_mem master port and the SRAM responder.
interface digital_mem_sram_if;
    logic [31:0] digital_mem_addr;
    logic        digital_mem_write_en;
    logic        digital_mem_read_en;
    logic [3:0]  digital_mem_byte_size;
    logic [31:0] digital_mem_wdata;
    logic [31:0] digital_mem_data;
    logic        digital_mem_ready;
    logic        digital_mem_err;

    modport master (
        output digital_mem_addr, digital_mem_write_en, digital_mem_read_en,
               digital_mem_byte_size, digital_mem_wdata,
        input  digital_mem_data, digital_mem_ready, digital_mem_err
    );

    modport slave (
        input  digital_mem_addr, digital_mem_write_en, digital_mem_read_en,
               digital_mem_byte_size, digital_mem_wdata,
        output digital_mem_data, digital_mem_ready, digital_mem_err
    );
endinterface

// File: rtl/digital_mem_sram_ram.sv
// Four 8-bit RAM banks sharing one word address: per-lane synchronous write,
// combinational word read.
module mem_byte_lane_ram #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int          AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[addr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = mem[addr];
        end
    endgenerate
endmodule

// File: rtl/digital_mem_sram.sv
// Byte/halfword/word SRAM responder for the digital_mem bus with a one-cycle ready pulse.
// Define DIGITAL_MEM_WAIT_EN to build the WAIT state and honour WAIT_CYCLES.
module digital_mem_sram
    import digital_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    digital_mem_sram_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    mem_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [31:0] data_q, data_d;
`ifdef DIGITAL_MEM_WAIT_EN
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
`endif

    // In IDLE the live bus is decoded so a zero-wait access can commit on its sampling edge.
    logic        idle, req;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_size;
    logic        cur_wr, cur_rd;
    assign idle      = (state_q == ST_IDLE);
    assign req       = bus.digital_mem_read_en | bus.digital_mem_write_en;
    assign cur_addr  = idle ? bus.digital_mem_addr      : addr_q;
    assign cur_size  = idle ? bus.digital_mem_byte_size : size_q;
    assign cur_wdata = idle ? bus.digital_mem_wdata     : wdata_q;
    assign cur_wr    = idle ? bus.digital_mem_write_en  : wr_q;
    assign cur_rd    = idle ? bus.digital_mem_read_en   : rd_q;

    logic       size_bad, misalign, out_range, conflict, err_cur;
    logic [1:0] lane_off;
    logic [3:0] lanes;
    assign size_bad  = !(cur_size inside {MEM_SZ_B, MEM_SZ_H, MEM_SZ_W});
    assign misalign  = ({3'b000, cur_addr[1:0]} + {1'b0, cur_size}) > 5'd4;
    assign out_range = cur_addr[31:AW+2] != BASE_ADDR[31:AW+2];
    assign conflict  = cur_wr & cur_rd;
    assign err_cur   = size_bad | misalign | out_range | conflict;
    assign lane_off  = cur_addr[1:0];
    assign lanes     = size_lanes(cur_size);

    logic        enter_resp;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata, ram_rdata, rd_val;
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign ram_we     = (enter_resp && cur_wr && !err_cur) ? (lanes << lane_off) : 4'b0000;
    assign ram_wdata  = cur_wdata << {lane_off, 3'b000};
    assign rd_val     = (ram_rdata >> {lane_off, 3'b000}) & lane_bits(lanes);

    mem_byte_lane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .addr  (cur_addr[AW+1:2]),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        data_d  = data_q;
`ifdef DIGITAL_MEM_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = bus.digital_mem_addr;
                    size_d  = bus.digital_mem_byte_size;
                    wdata_d = bus.digital_mem_wdata;
                    wr_d    = bus.digital_mem_write_en;
                    rd_d    = bus.digital_mem_read_en;
`ifdef DIGITAL_MEM_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
`else
                    state_d = ST_RESP;
`endif
                end
            end
            ST_WAIT: begin
`ifdef DIGITAL_MEM_WAIT_EN
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (enter_resp && cur_rd) begin
            data_d = err_cur ? 32'h0 : rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            data_q  <= '0;
`ifdef DIGITAL_MEM_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
`ifdef DIGITAL_MEM_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.digital_mem_ready = (state_q == ST_RESP);
    assign bus.digital_mem_err   = (state_q == ST_RESP) & err_cur;
    assign bus.digital_mem_data  = data_q;

endmodule

// File: tb/tb_digital_mem_sram.sv
// Directed bench for digital_mem_sram: word/byte/halfword traffic, error cases,
// reset during an access and back-to-back throughput.
module tb_digital_mem_sram;
    localparam int unsigned DEPTH       = 4096;
    localparam logic [31:0] BASE        = 32'h0001_0000;
    localparam int unsigned WAIT_CYCLES = 2;
`ifdef DIGITAL_MEM_WAIT_EN
    localparam int W = WAIT_CYCLES;
`else
    localparam int W = 0;
`endif
    localparam int          EXP_LAT = W + 1;
    localparam logic [31:0] A       = BASE + 32'h10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    digital_mem_sram_if mif ();

    digital_mem_sram #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One bus transaction; lat counts edges from the sampling edge to ready (0 on timeout).
    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [3:0] sz, input logic [31:0] wd,
                          output int lat, output logic [31:0] d, output logic e);
        mif.digital_mem_write_en  = wr;
        mif.digital_mem_read_en   = rd;
        mif.digital_mem_addr      = a;
        mif.digital_mem_byte_size = sz;
        mif.digital_mem_wdata     = wd;
        lat = 0;
        d   = 'x;
        e   = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (mif.digital_mem_ready === 1'b1) begin
                lat = k;
                d   = mif.digital_mem_data;
                e   = mif.digital_mem_err;
                break;
            end
            check("err_without_ready", {31'b0, mif.digital_mem_err}, 32'd0);
        end
        @(posedge clk);
        #1;
        mif.digital_mem_write_en = 1'b0;
        mif.digital_mem_read_en  = 1'b0;
        $display("txn wr=%0b rd=%0b addr=%h size=%0d wdata=%h -> lat=%0d data=%h err=%0b",
                 wr, rd, a, sz, wd, lat, d, e);
    endtask

    int          lat;
    logic [31:0] d;
    logic        e;
    logic [11:0] rdy_seen, rdy_exp;

    initial begin
        mif.digital_mem_write_en  = 1'b0;
        mif.digital_mem_read_en   = 1'b0;
        mif.digital_mem_addr      = '0;
        mif.digital_mem_byte_size = '0;
        mif.digital_mem_wdata     = '0;

        #3;
        check("reset_data",  mif.digital_mem_data, 32'h0);
        check("reset_ready", {31'b0, mif.digital_mem_ready}, 32'd0);
        check("reset_err",   {31'b0, mif.digital_mem_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        access(1'b1, 1'b0, A, 4'd4, 32'hDEAD_BEEF, lat, d, e);
        check("wr_word_lat", lat, EXP_LAT);
        check("wr_word_err", {31'b0, e}, 32'd0);
        access(1'b0, 1'b1, A, 4'd4, 32'h0, lat, d, e);
        check("rd_word_lat", lat, EXP_LAT);
        check("rd_word_data", d, 32'hDEAD_BEEF);
        check("rd_word_err", {31'b0, e}, 32'd0);

        access(1'b1, 1'b0, A + 1, 4'd1, 32'h0000_00AA, lat, d, e);
        check("wr_byte_err", {31'b0, e}, 32'd0);
        access(1'b0, 1'b1, A, 4'd4, 32'h0, lat, d, e);
        check("rd_after_byte", d, 32'hDEAD_AAEF);
        access(1'b0, 1'b1, A + 3, 4'd1, 32'h0, lat, d, e);
        check("rd_byte3", d, 32'h0000_00DE);
        access(1'b0, 1'b1, A + 1, 4'd2, 32'h0, lat, d, e);
        check("rd_half_off1", d, 32'h0000_ADAA);

        access(1'b0, 1'b1, A + 3, 4'd2, 32'h0, lat, d, e);
        check("misalign_rd_err", {31'b0, e}, 32'd1);
        check("misalign_rd_data", d, 32'h0);
        check("misalign_rd_lat", lat, EXP_LAT);

        access(1'b0, 1'b1, A, 4'd4, 32'h0, lat, d, e);
        check("rd_before_badwr", d, 32'hDEAD_AAEF);
        access(1'b1, 1'b0, A + 2, 4'd4, 32'hFFFF_FFFF, lat, d, e);
        check("misalign_wr_err", {31'b0, e}, 32'd1);
        check("wr_holds_data", d, 32'hDEAD_AAEF);

        access(1'b0, 1'b1, A, 4'd3, 32'h0, lat, d, e);
        check("size3_err", {31'b0, e}, 32'd1);
        access(1'b0, 1'b1, BASE + DEPTH * 4, 4'd4, 32'h0, lat, d, e);
        check("oor_high_err", {31'b0, e}, 32'd1);
        access(1'b0, 1'b1, BASE - 4, 4'd4, 32'h0, lat, d, e);
        check("oor_low_err", {31'b0, e}, 32'd1);
        access(1'b1, 1'b1, A, 4'd4, 32'h0000_0000, lat, d, e);
        check("conflict_err", {31'b0, e}, 32'd1);
        check("conflict_data", d, 32'h0);
        access(1'b0, 1'b1, A, 4'd4, 32'h0, lat, d, e);
        check("ram_unchanged", d, 32'hDEAD_AAEF);

        access(1'b1, 1'b0, BASE + DEPTH * 4 - 4, 4'd4, 32'hCAFE_F00D, lat, d, e);
        check("last_wr_err", {31'b0, e}, 32'd0);
        access(1'b0, 1'b1, BASE + DEPTH * 4 - 4, 4'd4, 32'h0, lat, d, e);
        check("last_rd_data", d, 32'hCAFE_F00D);

        // Reset right after the sampling edge of a word write.
        mif.digital_mem_write_en  = 1'b1;
        mif.digital_mem_addr      = A;
        mif.digital_mem_byte_size = 4'd4;
        mif.digital_mem_wdata     = 32'h1234_5678;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_ready", {31'b0, mif.digital_mem_ready}, 32'd0);
        check("midrst_err",   {31'b0, mif.digital_mem_err}, 32'd0);
        check("midrst_data",  mif.digital_mem_data, 32'h0);
        mif.digital_mem_write_en = 1'b0;
        $display("txn reset asserted during word write of 12345678");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        access(1'b0, 1'b1, A, 4'd4, 32'h0, lat, d, e);
        check("midrst_readback", d, (W > 0) ? 32'hDEAD_AAEF : 32'h1234_5678);

        // Enables held high: ready repeats every W+2 edges.
        mif.digital_mem_write_en  = 1'b1;
        mif.digital_mem_addr      = A + 4;
        mif.digital_mem_byte_size = 4'd4;
        mif.digital_mem_wdata     = 32'h1111_1111;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            rdy_seen[k-1] = mif.digital_mem_ready;
            rdy_exp[k-1]  = ((k % (W + 2)) == (W + 1));
        end
        mif.digital_mem_write_en = 1'b0;
        $display("txn back-to-back writes ready pattern=%b", rdy_seen);
        check("b2b_ready_pattern", {20'b0, rdy_seen}, {20'b0, rdy_exp});
        @(posedge clk);
        #1;
        access(1'b0, 1'b1, A + 4, 4'd4, 32'h0, lat, d, e);
        check("b2b_readback", d, 32'h1111_1111);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
